// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST definitions: controller-visible states and default MISR/LFSR constants
//
// Purpose : common types and constants for the BIST pattern generator and
//           output response analyzer.
// Contents: bist_state_e   - session state (IDLE / RUN / DONE)
//           BIST_POLY_DEFAULT - x^8+x^4+x^3+x^2+1 taps, x^8 implicit
//           BIST_SEED_DEFAULT - register value loaded at reset/session start
//           BIST_CNT_W     - width of the response counter
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    localparam logic [7:0] BIST_POLY_DEFAULT = 8'h1D;
    localparam logic [7:0] BIST_SEED_DEFAULT = 8'h00;
    localparam int         BIST_CNT_W        = 16;

endpackage

// File: rtl/misr_8bit.sv
// rtl/misr_8bit.sv - shift-XOR multiple-input signature register with load and enable
//
// Purpose : compacts one WIDTH-bit word per enabled cycle into the signature.
//           next = (sig << 1) ^ (sig[MSB] ? POLY : 0) ^ din
// Ports   : clk        - clock, rising edge
//           rst        - synchronous active-high reset, loads SEED
//           load_i     - reload SEED (has priority over en_i)
//           en_i       - compact din_i this edge
//           din_i      - parallel input word
//           sig_o      - registered signature
//           sig_next_o - value the signature takes if en_i is applied this edge
module misr_8bit
    import bist_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(BIST_POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(BIST_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_next_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] shifted;

    // Exposed so the owner can register a compare against the final value
    // on the same edge that stores it.
    always_comb begin
        shifted    = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0);
        sig_next_o = shifted ^ din_i;
    end

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = sig_next_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_ora_misr.sv
// rtl/bist_ora_misr.sv - BIST output response analyzer: MISR compaction, response count, golden compare
//
// Purpose : compacts PATTERNS CUT responses into a signature and reports
//           whether the final signature matches GOLDEN.
// Ports   : clk        - clock, rising edge
//           rst        - synchronous active-high reset
//           start      - begin a session (honoured in IDLE or DONE only)
//           resp_valid - resp holds a CUT response this cycle
//           resp       - CUT response word
//           busy       - session in progress
//           done       - session complete, held until next start or rst
//           pass       - final signature == GOLDEN, meaningful while done
//           signature  - current MISR contents
//           count      - responses accepted in the current session
module bist_ora_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               PATTERNS = 255,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(BIST_POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(BIST_SEED_DEFAULT),
    parameter logic [WIDTH-1:0] GOLDEN   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  resp_valid,
    input  logic [WIDTH-1:0]      resp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [WIDTH-1:0]      signature,
    output logic [BIST_CNT_W-1:0] count
);

    // Count value just before the final response is accepted.
    localparam logic [BIST_CNT_W-1:0] LAST_CNT = BIST_CNT_W'(PATTERNS - 1);

    bist_state_e           state_q, state_d;
    logic [BIST_CNT_W-1:0] count_q, count_d;
    logic                  pass_q, pass_d;
    logic                  misr_load;
    logic                  misr_en;
    logic [WIDTH-1:0]      misr_sig;
    logic [WIDTH-1:0]      misr_next;

    misr_8bit #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (misr_load),
        .en_i       (misr_en),
        .din_i      (resp),
        .sig_o      (misr_sig),
        .sig_next_o (misr_next)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // start beats a coincident resp_valid: nothing is compacted.
                if (start) begin
                    state_d   = RUN;
                    count_d   = '0;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end

            RUN: begin
                if (resp_valid) begin
                    misr_en = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d = DONE;
                        pass_d  = (misr_next == GOLDEN);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = misr_sig;
    assign count     = count_q;

endmodule

// File: tb/tb_bist_ora_misr.sv
// tb/tb_bist_ora_misr.sv - self-checking bench for bist_ora_misr
module tb_bist_ora_misr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       resp_valid = 1'b0;
    logic [7:0] resp = 8'h00;

    logic        a_busy, a_done, a_pass;
    logic [7:0]  a_sig;
    logic [15:0] a_cnt;
    logic        b_busy, b_done, b_pass;
    logic [7:0]  b_sig;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bist_ora_misr #(.WIDTH(8), .PATTERNS(2), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00)) dut_a (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .count(a_cnt)
    );

    bist_ora_misr #(.WIDTH(8), .PATTERNS(5), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h3C)) dut_b (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .count(b_cnt)
    );

    // Behavioural model: phase 0=idle, 1=running, 2=finished.
    typedef struct {
        int       phase;
        logic [7:0] sig;
        int       cnt;
        bit       pass;
    } mdl_t;

    mdl_t ma, mb;

    // One compaction step as GF(2) polynomial arithmetic: s*x mod (x^8+x^4+x^3+x^2+1), plus r.
    function automatic logic [7:0] fold(logic [7:0] s, logic [7:0] r);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit r_rst, bit r_st, bit r_v, logic [7:0] r_d,
                                      int pats, logic [7:0] gold);
        mdl_t n;
        n = m;
        if (r_rst) begin
            n.phase = 0; n.sig = 8'h00; n.cnt = 0; n.pass = 1'b0;
        end else if (m.phase != 1) begin
            if (r_st) begin
                n.phase = 1; n.sig = 8'h00; n.cnt = 0; n.pass = 1'b0;
            end
        end else if (r_v) begin
            n.sig = fold(m.sig, r_d);
            n.cnt = m.cnt + 1;
            if (n.cnt == pats) begin
                n.phase = 2;
                n.pass  = (n.sig == gold);
            end
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma = mdl_step(ma, rst, start, resp_valid, resp, 2, 8'h00);
        mb = mdl_step(mb, rst, start, resp_valid, resp, 5, 8'h3C);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.busy", int'(a_busy), int'(ma.phase == 1));
            chk("a.done", int'(a_done), int'(ma.phase == 2));
            chk("a.pass", int'(a_pass), int'(ma.pass));
            chk("a.signature", int'(a_sig), int'(ma.sig));
            chk("a.count", int'(a_cnt), ma.cnt);
            chk("b.busy", int'(b_busy), int'(mb.phase == 1));
            chk("b.done", int'(b_done), int'(mb.phase == 2));
            chk("b.pass", int'(b_pass), int'(mb.pass));
            chk("b.signature", int'(b_sig), int'(mb.sig));
            chk("b.count", int'(b_cnt), mb.cnt);
        end
    end

    task automatic step(bit r, bit s, bit v, logic [7:0] d);
        rst = r; start = s; resp_valid = v; resp = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         rr, ss, vv;
        logic [7:0] dd;

        ma = '{0, 8'h00, 0, 1'b0};
        mb = '{0, 8'h00, 0, 1'b0};
        step(1, 0, 0, 8'h00);
        chk_en = 1'b1;

        // Reset during an active session
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h5A);
        chk("t1.mid_sig", int'(a_sig), 8'h5A);
        step(1, 0, 1, 8'h33);
        step(1, 0, 1, 8'h33);
        chk("t1.sig", int'(a_sig), 8'h00);
        chk("t1.count", int'(a_cnt), 0);
        chk("t1.busy", int'(a_busy), 0);
        chk("t1.done", int'(a_done), 0);
        chk("t1.pass", int'(a_pass), 0);

        // Basic pass session
        step(0, 1, 0, 8'h00);
        chk("t2.busy", int'(a_busy), 1);
        step(0, 0, 1, 8'h01);
        chk("t2.sig1", int'(a_sig), 8'h01);
        step(0, 0, 1, 8'h02);
        chk("t2.sig2", int'(a_sig), 8'h00);
        chk("t2.done", int'(a_done), 1);
        chk("t2.busy", int'(a_busy), 0);
        chk("t2.pass", int'(a_pass), 1);
        chk("t2.count", int'(a_cnt), 2);

        // Failing session, DONE holds while resp_valid toggles
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h03);
        chk("t3.sig", int'(a_sig), 8'h01);
        chk("t3.pass", int'(a_pass), 0);
        chk("t3.done", int'(a_done), 1);
        for (int i = 0; i < 4; i++) step(0, 0, i[0], 8'hC7);
        chk("t3.sig_hold", int'(a_sig), 8'h01);
        chk("t3.count_hold", int'(a_cnt), 2);

        // Restart from DONE with coincident response
        step(0, 1, 1, 8'hFF);
        chk("t6.done", int'(a_done), 0);
        chk("t6.pass", int'(a_pass), 0);
        chk("t6.sig", int'(a_sig), 8'h00);
        chk("t6.count", int'(a_cnt), 0);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h02);
        chk("t6.pass_end", int'(a_pass), 1);

        // MSB feedback
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h80);
        chk("t4.sig1", int'(a_sig), 8'h80);
        step(0, 0, 1, 8'h00);
        chk("t4.sig2", int'(a_sig), 8'h1D);
        chk("t4.pass", int'(a_pass), 0);

        // Stalls and ignored mid-session start
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h01);
        step(0, 0, 0, 8'hAA);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h55);
        chk("t5.stall_sig", int'(a_sig), 8'h01);
        chk("t5.stall_count", int'(a_cnt), 1);
        chk("t5.busy", int'(a_busy), 1);
        step(0, 0, 1, 8'h02);
        chk("t5.sig", int'(a_sig), 8'h00);
        chk("t5.pass", int'(a_pass), 1);
        chk("t5.count", int'(a_cnt), 2);

        // Randomized traffic, biased so the 5-pattern instance sometimes passes
        for (int i = 0; i < 800; i++) begin
            rr = ($urandom_range(0, 63) == 0);
            ss = ($urandom_range(0, 5) == 0);
            vv = $urandom_range(0, 1) == 1;
            dd = 8'($urandom);
            if (mb.phase == 1 && mb.cnt == 4 && $urandom_range(0, 1) == 1)
                dd = fold(mb.sig, 8'h00) ^ 8'h3C;
            step(rr, ss, vv, dd);
        end

        step(0, 0, 0, 8'h00);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
